// File: rtl/collatz_sweep.sv
// collatz_sweep: drives an external Collatz engine across a range of
// candidates and keeps longest-orbit / highest-path statistics.
module collatz_sweep #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITS-1:0]     cfg_base,
    input  logic [CNT_BITS-1:0] cfg_count,
    input  logic                go,
    output logic                core_start,
    output logic [BITS-1:0]     core_num,
    input  logic                core_done,
    input  logic [BITS-1:0]     core_orbit_len,
    input  logic [BITS-1:0]     core_path_record,
    input  logic                core_overflow,
    output logic                busy,
    output logic                done,
    output logic [BITS-1:0]     best_num,
    output logic [BITS-1:0]     best_orbit_len,
    output logic [BITS-1:0]     max_path_num,
    output logic [BITS-1:0]     max_path,
    output logic [CNT_BITS-1:0] processed,
    output logic [CNT_BITS-1:0] ovf_count
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [BITS-1:0]     cand;
    logic [CNT_BITS-1:0] remaining;
    logic [BITS-1:0]     res_orbit;
    logic [BITS-1:0]     res_path;
    logic                res_ovf;

    assign core_num = cand;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (go)
                    state_nxt = (cfg_count == '0) ? DONE : LAUNCH;
            end
            LAUNCH: begin
                busy       = 1'b1;
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (core_done) state_nxt = UPDATE;
            end
            UPDATE: begin
                busy      = 1'b1;
                state_nxt = (remaining == CNT_BITS'(1)) ? DONE : LAUNCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: candidate walk, result capture and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            cand           <= '0;
            remaining      <= '0;
            res_orbit      <= '0;
            res_path       <= '0;
            res_ovf        <= 1'b0;
            best_num       <= '0;
            best_orbit_len <= '0;
            max_path_num   <= '0;
            max_path       <= '0;
            processed      <= '0;
            ovf_count      <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        cand           <= cfg_base;
                        remaining      <= cfg_count;
                        best_num       <= '0;
                        best_orbit_len <= '0;
                        max_path_num   <= '0;
                        max_path       <= '0;
                        processed      <= '0;
                        ovf_count      <= '0;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        res_orbit <= core_orbit_len;
                        res_path  <= core_path_record;
                        res_ovf   <= core_overflow;
                    end
                end
                UPDATE: begin
                    processed <= processed + CNT_BITS'(1);
                    if (res_ovf) begin
                        ovf_count <= ovf_count + CNT_BITS'(1);
                    end else begin
                        if (res_orbit > best_orbit_len) begin
                            best_num       <= cand;
                            best_orbit_len <= res_orbit;
                        end
                        if (res_path > max_path) begin
                            max_path_num <= cand;
                            max_path     <= res_path;
                        end
                    end
                    remaining <= remaining - CNT_BITS'(1);
                    cand      <= cand + BITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/collatz_sweep.md
COLLATZ_SWEEP -- requirements
Module: collatz_sweep

Interface
REQ-001 SHALL have parameter BITS, default 32, width of candidate and result values.
REQ-002 SHALL have parameter CNT_BITS, default 16, width of sweep count and statistics counters.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_base  input  BITS  first candidate of the sweep.
REQ-006 SHALL have port cfg_count  input  CNT_BITS  number of candidates to sweep.
REQ-007 SHALL have port go  input  1  start-sweep pulse, sampled only in IDLE or DONE.
REQ-008 SHALL have port core_start  output  1  one-cycle launch pulse to the Collatz engine.
REQ-009 SHALL have port core_num  output  BITS  candidate presented to the engine, valid while core_start=1.
REQ-010 SHALL have port core_done  input  1  one-cycle engine completion pulse.
REQ-011 SHALL have port core_orbit_len  input  BITS  engine orbit length, valid with core_done.
REQ-012 SHALL have port core_path_record  input  BITS  engine path maximum, valid with core_done.
REQ-013 SHALL have port core_overflow  input  1  engine overflow flag, valid with core_done.
REQ-014 SHALL have ports busy/done  output  1 each  sweep running / sweep finished.
REQ-015 SHALL have ports best_num, best_orbit_len  output  BITS each  candidate with longest orbit and that length.
REQ-016 SHALL have ports max_path_num, max_path  output  BITS each  candidate with highest path record and that record.
REQ-017 SHALL have ports processed, ovf_count  output  CNT_BITS each  results consumed / overflowed results.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, UPDATE, DONE; busy=1 exactly in LAUNCH, WAIT, UPDATE; done=1 exactly in DONE.
REQ-019 IDLE/DONE + go=1 SHALL latch cfg_base into cand, cfg_count into remaining, clear all statistics outputs to 0, and go to LAUNCH; if cfg_count=0 go directly to DONE instead.
REQ-020 LAUNCH SHALL assert core_start=1 with core_num=cand for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL hold until core_done=1, registering the three result inputs that cycle, then go to UPDATE; core_start=0 throughout.
REQ-022 UPDATE SHALL increment processed; if overflow, increment ovf_count and leave best/max outputs unchanged.
REQ-023 UPDATE, no overflow: if orbit_len > best_orbit_len (strict), load best_num=cand, best_orbit_len=orbit_len; ties keep the earlier candidate.
REQ-024 UPDATE, no overflow: if path_record > max_path (strict), load max_path_num=cand, max_path=path_record.
REQ-025 UPDATE SHALL decrement remaining and increment cand modulo 2^BITS; if remaining becomes 0 go to DONE, else LAUNCH.
REQ-026 Launch-to-launch overhead SHALL be 3 cycles plus engine latency; core_done to DONE SHALL be 2 cycles.
REQ-027 go SHALL be ignored in LAUNCH, WAIT, UPDATE; core_done SHALL be ignored outside WAIT.
REQ-028 Statistics outputs SHALL hold their values in DONE until the next accepted go.
REQ-029 ovf_count and processed SHALL never exceed cfg_count, so no wrap handling is required.
REQ-030 cand wrap from 2^BITS-1 to 0 SHALL be legal; candidate 0 SHALL be launched like any other.

Reset
REQ-031 reset=1 SHALL force IDLE, core_start=0, busy=0, done=0, and all statistics and internal registers to 0 on the next rising edge, including mid-sweep.
REQ-032 reset SHALL take priority over go and core_done in the same cycle.

Verification (bench drives engine with a behavioural Collatz model, latency N)
REQ-033 base=27, count=1, go -> one core_start with core_num=27; DONE with best_num=27, best_orbit_len=111, max_path=9232, processed=1, ovf_count=0.
REQ-034 base=1, count=10 -> 10 launches, core_num 1..10 in order; best_num=9, best_orbit_len=19, max_path_num=7, max_path=52.
REQ-035 count=0, go -> done=1 one cycle later, no core_start, all statistics 0.
REQ-036 model flags overflow on candidate 5 of base=3, count=4 -> ovf_count=1, processed=4, candidate 5 never appears in best/max outputs.
REQ-037 reset asserted while in WAIT, then core_done pulsed -> stays IDLE, outputs 0; later go runs normally.
REQ-038 base=2^BITS-1, count=2 -> second core_num=0; go pulses during busy produce no extra launches.
